// File: rtl/iobus_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : iobus_uart_tx
// Purpose  : Memory-mapped 8N1 UART transmitter acting as an OTTER IOBUS
//            responder. CPU stores are decoded into register writes. Transmit
//            bytes are buffered in a small FIFO and serialized on TX. Status
//            is returned combinationally on IO_RD_DATA, and a registered level
//            interrupt can be raised when transmission has drained.
// Ports    : CLK         - system clock, rising edge active
//            RESET       - asynchronous active-low reset
//            IOBUS_ADDR  - CPU IO address
//            IOBUS_OUT   - CPU store data
//            IOBUS_WR    - store strobe, one write per high cycle
//            IO_RD_DATA  - register readback for the CPU's IOBUS_IN
//            TX          - serial output, idles high
//            INTR        - level interrupt request
// Registers: +0x0 TXDATA (wo), +0x4 STATUS (ro, write clears overflow),
//            +0x8 CTRL {irq_en, enable}, +0xC BAUDDIV[15:0]
// Revision : 1.0 - initial release
// ============================================================================
module iobus_uart_tx #(
   parameter logic [31:0] BASE_ADDR  = 32'h1100_0300,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RESET  = 16'd867
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] IOBUS_ADDR,
   input  logic [31:0] IOBUS_OUT,
   input  logic        IOBUS_WR,
   output logic [31:0] IO_RD_DATA,
   output logic        TX,
   output logic        INTR
);

   localparam int             AW       = $clog2(FIFO_DEPTH);
   localparam int             CW       = AW + 1;
   localparam logic [CW-1:0]  FULL_CNT = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   // ------------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------------
   logic       in_win;
   logic [1:0] reg_sel;
   logic       wr_txdata, wr_status, wr_ctrl, wr_baud;

   assign in_win    = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
   assign reg_sel   = IOBUS_ADDR[3:2];
   assign wr_txdata = IOBUS_WR & in_win & (reg_sel == 2'd0);
   assign wr_status = IOBUS_WR & in_win & (reg_sel == 2'd1);
   assign wr_ctrl   = IOBUS_WR & in_win & (reg_sel == 2'd2);
   assign wr_baud   = IOBUS_WR & in_win & (reg_sel == 2'd3);

   // Byte-lane and sub-word address bits have no meaning for this block.
   logic unused_bits;
   assign unused_bits = ^{IOBUS_ADDR[1:0], IOBUS_OUT[31:16]};

   // ------------------------------------------------------------------------
   // Control registers and FIFO bookkeeping
   // ------------------------------------------------------------------------
   logic          enable_q, irq_en_q, ovf_q, ovf_d;
   logic [15:0]   baud_q;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          full, empty, push, pop;

   state_t        state_q;
   logic [7:0]    shift_q;
   logic [15:0]   cnt_q;
   logic [2:0]    bit_idx_q;
   logic          tx_q, intr_q;

   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);
   assign pop   = (state_q == ST_IDLE) & enable_q & ~empty;
   // A same-cycle pop frees a slot, so a push at full is still accepted.
   assign push  = wr_txdata & (~full | pop);

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      ovf_d = ovf_q;
      if (wr_status) begin
         ovf_d = 1'b0;
      end else if (wr_txdata & full & ~pop) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         enable_q <= 1'b0;
         irq_en_q <= 1'b0;
         baud_q   <= DIV_RESET;
         ovf_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_ctrl) begin
            enable_q <= IOBUS_OUT[0];
            irq_en_q <= IOBUS_OUT[1];
         end
         if (wr_baud) begin
            baud_q <= IOBUS_OUT[15:0];
         end
         ovf_q   <= ovf_d;
         count_q <= count_d;
         // Power-of-two depth: pointers wrap naturally.
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
      end
   end

   // Storage needs no reset; occupancy is tracked by count_q.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem_q[wr_ptr_q] <= IOBUS_OUT[7:0];
      end
   end

   // ------------------------------------------------------------------------
   // Transmit state machine. cnt_q counts down the remaining cycles of the
   // current bit and is reloaded from baud_q at every bit boundary, so a
   // BAUDDIV change lands on the next bit.
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q   <= ST_IDLE;
         shift_q   <= 8'h00;
         cnt_q     <= 16'h0000;
         bit_idx_q <= 3'd0;
         tx_q      <= 1'b1;
         intr_q    <= 1'b0;
      end else begin
         intr_q <= irq_en_q & empty & (state_q == ST_IDLE);
         case (state_q)
            ST_IDLE: begin
               tx_q <= 1'b1;
               if (pop) begin
                  shift_q <= mem_q[rd_ptr_q];
                  cnt_q   <= baud_q;
                  tx_q    <= 1'b0;
                  state_q <= ST_START;
               end
            end
            ST_START: begin
               if (cnt_q == 16'h0000) begin
                  state_q   <= ST_DATA;
                  bit_idx_q <= 3'd0;
                  cnt_q     <= baud_q;
                  tx_q      <= shift_q[0];
               end else begin
                  cnt_q <= cnt_q - 16'd1;
               end
            end
            ST_DATA: begin
               if (cnt_q == 16'h0000) begin
                  cnt_q <= baud_q;
                  if (bit_idx_q == 3'd7) begin
                     state_q <= ST_STOP;
                     tx_q    <= 1'b1;
                  end else begin
                     // Present the next bit directly from shift_q[1] so TX
                     // changes in the same edge the shift happens.
                     shift_q   <= {1'b0, shift_q[7:1]};
                     tx_q      <= shift_q[1];
                     bit_idx_q <= bit_idx_q + 3'd1;
                  end
               end else begin
                  cnt_q <= cnt_q - 16'd1;
               end
            end
            ST_STOP: begin
               if (cnt_q == 16'h0000) begin
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q - 16'd1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               tx_q    <= 1'b1;
            end
         endcase
      end
   end

   assign TX   = tx_q;
   assign INTR = intr_q;

   // ------------------------------------------------------------------------
   // Combinational readback
   // ------------------------------------------------------------------------
   logic busy;
   assign busy = (state_q != ST_IDLE);

   always_comb begin
      IO_RD_DATA = 32'h0000_0000;
      if (in_win) begin
         case (reg_sel)
            2'd1:    IO_RD_DATA = {16'h0000, {(8-CW){1'b0}}, count_q,
                                   4'h0, ovf_q, busy, empty, full};
            2'd2:    IO_RD_DATA = {30'h0, irq_en_q, enable_q};
            2'd3:    IO_RD_DATA = {16'h0000, baud_q};
            default: IO_RD_DATA = 32'h0000_0000;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_iobus_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_iobus_uart_tx
// Purpose  : Directed bench for iobus_uart_tx. Bytes accepted by the FIFO are
//            queued as expected frames and compared bit by bit against TX.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iobus_uart_tx;

   localparam logic [31:0] BASE   = 32'h1100_0300;
   localparam logic [31:0] A_TX   = BASE + 32'h0;
   localparam logic [31:0] A_STAT = BASE + 32'h4;
   localparam logic [31:0] A_CTRL = BASE + 32'h8;
   localparam logic [31:0] A_BAUD = BASE + 32'hC;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic [31:0] IOBUS_ADDR = 32'h0;
   logic [31:0] IOBUS_OUT = 32'h0;
   logic        IOBUS_WR = 1'b0;
   logic [31:0] IO_RD_DATA;
   logic        TX;
   logic        INTR;

   int vec  = 0;
   int errs = 0;
   logic [7:0] sb [$];

   iobus_uart_tx dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .IOBUS_ADDR (IOBUS_ADDR),
      .IOBUS_OUT  (IOBUS_OUT),
      .IOBUS_WR   (IOBUS_WR),
      .IO_RD_DATA (IO_RD_DATA),
      .TX         (TX),
      .INTR       (INTR)
   );

   always #5 CLK = ~CLK;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at a falling edge; the write is captured at the next rising edge.
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      IOBUS_ADDR = a;
      IOBUS_OUT  = d;
      IOBUS_WR   = 1'b1;
      @(negedge CLK);
      IOBUS_WR   = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input bit accept);
      bus_write(A_TX, {24'h0, b});
      if (accept) sb.push_back(b);
   endtask

   task automatic chk_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
      IOBUS_ADDR = a;
      #1;
      check(tag, IO_RD_DATA, exp);
   endtask

   task automatic wait_start(output int n);
      n = 0;
      while (TX !== 1'b0 && n < 200) begin
         @(negedge CLK);
         n++;
      end
   endtask

   // Entered on the first start-bit cycle; leaves on the cycle after STOP.
   task automatic rx_frame(input int bd, input string tag);
      logic [7:0] e;
      logic [9:0] pat;
      int bad;
      check({tag, "_sb"}, 32'(sb.size() > 0), 32'd1);
      e = (sb.size() > 0) ? sb.pop_front() : 8'h00;
      pat = {1'b1, e, 1'b0};
      bad = 0;
      IOBUS_ADDR = A_STAT;
      #1;
      for (int b = 0; b < 10; b++) begin
         for (int c = 0; c <= bd; c++) begin
            if (TX !== pat[b]) bad++;
            if (IO_RD_DATA[2] !== 1'b1) bad++;
            if (INTR !== 1'b0) bad++;
            @(negedge CLK);
         end
      end
      check(tag, 32'(bad), 32'd0);
   endtask

   initial begin
      int n;
      int bad;
      logic [7:0] e;
      logic [9:0] pat;

      // ---------------- reset and readback ----------------
      repeat (3) @(negedge CLK);
      check("rst_tx", {31'h0, TX}, 32'd1);
      check("rst_intr", {31'h0, INTR}, 32'd0);
      RESET = 1'b1;
      @(negedge CLK);
      chk_reg("rst_status", A_STAT, 32'h0000_0002);
      chk_reg("rst_ctrl", A_CTRL, 32'h0);
      chk_reg("rst_baud", A_BAUD, 32'd867);
      chk_reg("outside_rd", BASE + 32'h10, 32'h0);
      @(negedge CLK);
      bus_write(BASE + 32'h10, 32'h55);
      chk_reg("outside_wr", A_STAT, 32'h0000_0002);
      @(negedge CLK);
      bus_write(A_BAUD, 32'd3);
      chk_reg("baud_3", A_BAUD, 32'd3);
      @(negedge CLK);
      bus_write(A_CTRL, 32'hFFFF_FFFE);
      chk_reg("ctrl_mask", A_CTRL, 32'h2);
      @(negedge CLK);
      check("intr_idle", {31'h0, INTR}, 32'd1);
      bus_write(A_CTRL, 32'h0);
      repeat (2) @(negedge CLK);

      // ---------------- single frame ----------------
      bus_write(A_CTRL, 32'h1);
      send(8'hA5, 1'b1);
      check("sf_tx_n1", {31'h0, TX}, 32'd1);
      chk_reg("sf_stat_n1", A_STAT, 32'h0000_0100);
      @(negedge CLK);
      wait_start(n);
      check("sf_latency", 32'(n), 32'd0);
      rx_frame(3, "sf_frame");
      chk_reg("sf_idle", A_STAT, 32'h0000_0002);

      // ---------------- overflow ----------------
      @(negedge CLK);
      bus_write(A_CTRL, 32'h0);
      bus_write(A_BAUD, 32'd1);
      for (int i = 0; i < 9; i++) send(8'h30 + 8'(i), i < 8);
      chk_reg("ovf_status", A_STAT, 32'h0000_0809);
      @(negedge CLK);
      bus_write(A_STAT, 32'h0);
      chk_reg("ovf_clear", A_STAT, 32'h0000_0801);
      @(negedge CLK);
      bus_write(A_CTRL, 32'h1);
      wait_start(n);
      check("ovf_first", 32'(n), 32'd1);
      for (int i = 0; i < 8; i++) begin
         rx_frame(1, "ovf_frame");
         if (i < 7) begin
            wait_start(n);
            check("ovf_gap", 32'(n), 32'd1);
         end
      end
      chk_reg("ovf_drained", A_STAT, 32'h0000_0002);
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge CLK);
         if (TX !== 1'b1) bad++;
      end
      check("ovf_no9th", 32'(bad), 32'd0);
      check("ovf_sb_empty", 32'(sb.size()), 32'd0);

      // ---------------- push at full with same-cycle pop ----------------
      bus_write(A_CTRL, 32'h0);
      bus_write(A_BAUD, 32'd0);
      for (int i = 0; i < 8; i++) send(8'hC0 + 8'(i), 1'b1);
      bus_write(A_CTRL, 32'h1);
      wait_start(n);
      check("pf_first", 32'(n), 32'd1);
      e = sb.pop_front();
      pat = {1'b1, e, 1'b0};
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         if (k == 1) IOBUS_WR = 1'b0;
         if (TX !== pat[k]) bad++;
         if (k == 0) begin
            IOBUS_ADDR = A_TX;
            IOBUS_OUT  = 32'hC8;
            IOBUS_WR   = 1'b1;
            sb.push_back(8'hC8);
         end
         @(negedge CLK);
      end
      check("pf_frame0", 32'(bad), 32'd0);
      chk_reg("pf_full_idle", A_STAT, 32'h0000_0801);
      IOBUS_ADDR = A_TX;
      IOBUS_OUT  = 32'hC9;
      IOBUS_WR   = 1'b1;
      sb.push_back(8'hC9);
      @(negedge CLK);
      IOBUS_WR = 1'b0;
      chk_reg("pf_after_push", A_STAT, 32'h0000_0805);
      for (int i = 0; i < 9; i++) begin
         rx_frame(0, "pf_frame");
         if (i < 8) begin
            wait_start(n);
            check("pf_gap", 32'(n), 32'd1);
         end
      end
      chk_reg("pf_drained", A_STAT, 32'h0000_0002);

      // ---------------- interrupt ----------------
      @(negedge CLK);
      bus_write(A_BAUD, 32'd1);
      bus_write(A_CTRL, 32'h3);
      @(negedge CLK);
      check("irq_pre", {31'h0, INTR}, 32'd1);
      send(8'h96, 1'b1);
      send(8'h3C, 1'b1);
      check("irq_fall", {31'h0, INTR}, 32'd0);
      rx_frame(1, "irq_frame1");
      wait_start(n);
      check("irq_gap", 32'(n), 32'd1);
      rx_frame(1, "irq_frame2");
      check("irq_stop_end", {31'h0, INTR}, 32'd0);
      @(negedge CLK);
      check("irq_rise", {31'h0, INTR}, 32'd1);
      send(8'hE1, 1'b1);
      check("irq_hold", {31'h0, INTR}, 32'd1);
      @(negedge CLK);
      check("irq_push_clr", {31'h0, INTR}, 32'd0);
      rx_frame(1, "irq_frame3");
      @(negedge CLK);
      check("irq_rise2", {31'h0, INTR}, 32'd1);
      bus_write(A_CTRL, 32'h1);
      check("irq_en_hold", {31'h0, INTR}, 32'd1);
      @(negedge CLK);
      check("irq_en_clr", {31'h0, INTR}, 32'd0);

      // ---------------- reset mid-frame ----------------
      bus_write(A_BAUD, 32'd3);
      bus_write(A_TX, 32'h5A);
      wait_start(n);
      check("rm_start", 32'(n), 32'd1);
      bus_write(A_TX, 32'h77);
      repeat (12) @(negedge CLK);
      check("rm_bit2", {31'h0, TX}, 32'd0);
      #2;
      RESET = 1'b0;
      #1;
      check("rm_tx_async", {31'h0, TX}, 32'd1);
      @(negedge CLK);
      @(negedge CLK);
      RESET = 1'b1;
      chk_reg("rm_status", A_STAT, 32'h0000_0002);
      chk_reg("rm_baud", A_BAUD, 32'd867);
      @(negedge CLK);
      bus_write(A_CTRL, 32'h1);
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         if (TX !== 1'b1) bad++;
         @(negedge CLK);
      end
      check("rm_no_frames", 32'(bad), 32'd0);
      chk_reg("rm_status_end", A_STAT, 32'h0000_0002);

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
`default_nettype wire
